// File: rtl/wb_interconnect_pkg.sv
// Shared address map, FSM state type and sizing helper for the Wishbone interconnect.
// Entries beyond the four populated slaves use an impossible base/mask pair so they never decode.
package wb_interconnect_pkg;

    localparam int MAX_SLAVES = 8;

    localparam logic [31:0] SLAVE_BASE [MAX_SLAVES] = '{
        32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h2000_1000,
        32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001
    };

    localparam logic [31:0] SLAVE_MASK [MAX_SLAVES] = '{
        32'hF000_0000, 32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
    };

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR
    } ic_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_interconnect_if.sv
// Master-side and slave-side Wishbone signals of the interconnect; 'slave' is the interconnect's view,
// 'master' is the view of the environment (core controller plus slave devices) driving it.
interface wb_interconnect_if #(
    parameter int NUM_SLAVES = 4
);
    logic [31:0]                  m_adr_i;
    logic [31:0]                  m_dat_i;
    logic [3:0]                   m_sel_i;
    logic                         m_we_i;
    logic                         m_cyc_i;
    logic                         m_stb_i;
    logic [31:0]                  m_dat_o;
    logic                         m_ack_o;
    logic                         m_err_o;
    logic [31:0]                  s_adr_o;
    logic [31:0]                  s_dat_o;
    logic [3:0]                   s_sel_o;
    logic                         s_we_o;
    logic [NUM_SLAVES-1:0]        s_cyc_o;
    logic [NUM_SLAVES-1:0]        s_stb_o;
    logic [NUM_SLAVES-1:0][31:0]  s_dat_i;
    logic [NUM_SLAVES-1:0]        s_ack_i;

    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
    );
endinterface

// File: rtl/wb_addr_decoder.sv
// Combinational address decoder: zero latency, no flow control; lowest-numbered matching slave wins.
module wb_addr_decoder
    import wb_interconnect_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int IDXW       = 2
) (
    input  logic [31:0]     adr,
    output logic            hit,
    output logic [IDXW-1:0] idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Scan high to low so the last assignment belongs to the lowest matching index.
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((adr & SLAVE_MASK[k]) == SLAVE_BASE[k]) begin
                hit = 1'b1;
                idx = IDXW'(k);
            end
        end
    end

endmodule

// File: rtl/wb_interconnect.sv
// Single-master Wishbone interconnect: strobe and ack pass through combinationally, read data follows one cycle later.
// Master stalls until the granted slave acks; unmapped accesses (and, with WB_TIMEOUT_EN, hung ones) end in ack+err.
module wb_interconnect
    import wb_interconnect_pkg::*;
#(
    parameter int          NUM_SLAVES     = 4,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] DEFAULT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              reset_n,
    wb_interconnect_if.slave  bus
);

    localparam int IDXW = idx_width(NUM_SLAVES);

    ic_state_t             state_q, state_d;
    logic [IDXW-1:0]       grant_q, grant_d;
    logic [IDXW-1:0]       rsel_q, ack_idx;
    logic                  rerr_q;
    logic                  req, dec_hit, ack, err;
    logic [IDXW-1:0]       dec_idx;
    logic [NUM_SLAVES-1:0] sel;

    assign req = bus.m_cyc_i & bus.m_stb_i;

    wb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .IDXW       (IDXW)
    ) u_dec (
        .adr (bus.m_adr_i),
        .hit (dec_hit),
        .idx (dec_idx)
    );

`ifdef WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q;

    always_ff @(posedge clk) begin
        if (!reset_n || state_q != WAIT || ack) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ack_idx = grant_q;
        sel     = '0;
        ack     = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && dec_hit) begin
                    sel[dec_idx] = 1'b1;
                    ack_idx      = dec_idx;
                    if (bus.s_ack_i[dec_idx]) begin
                        ack = 1'b1;
                    end else begin
                        state_d = WAIT;
                        grant_d = dec_idx;
                    end
                end else if (req) begin
                    ack = 1'b1;
                    err = 1'b1;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                end else begin
                    // Address is ignored here: the slave owns the cycle until it acks.
                    sel[grant_q] = 1'b1;
                    if (bus.s_ack_i[grant_q]) begin
                        ack     = 1'b1;
                        state_d = IDLE;
                    end
`ifdef WB_TIMEOUT_EN
                    // Timer reaches TIMEOUT_CYCLES-1 at this edge with still no ack.
                    else if (timer_q == TW'(TIMEOUT_CYCLES - 2)) begin
                        state_d = ERR;
                    end
`endif
                end
            end
`ifdef WB_TIMEOUT_EN
            ERR: begin
                ack     = 1'b1;
                err     = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rsel_q  <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (ack) begin
                rsel_q <= ack_idx;
                rerr_q <= err;
            end
        end
    end

    assign bus.s_adr_o = bus.m_adr_i;
    assign bus.s_dat_o = bus.m_dat_i;
    assign bus.s_sel_o = bus.m_sel_i;
    assign bus.s_we_o  = bus.m_we_i;
    assign bus.s_cyc_o = sel;
    assign bus.s_stb_o = sel;
    assign bus.m_ack_o = ack;
    assign bus.m_err_o = err;
    assign bus.m_dat_o = rerr_q ? DEFAULT_RDATA : bus.s_dat_i[rsel_q];

endmodule

// File: tb/tb_wb_interconnect.sv
// Scoreboarded random bench for wb_interconnect with latency-programmable slave models.
module tb_wb_interconnect;

    localparam int          NS  = 4;
    localparam int          TO  = 8;
    localparam logic [31:0] DEF = 32'hDEAD_BEEF;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    wb_interconnect_if #(.NUM_SLAVES(NS)) bus ();

    wb_interconnect #(
        .NUM_SLAVES     (NS),
        .TIMEOUT_CYCLES (TO),
        .DEFAULT_RDATA  (DEF)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;
    logic [31:0] slave_data [NS];
    int          lat [NS];
    int          cnt [NS];
    logic [NS-1:0] hang  = '0;
    logic [NS-1:0] stray = '0;

    // Slave models: ack once strobed for lat cycles, unless hung; stray injects unsolicited acks.
    always_comb begin
        for (int k = 0; k < NS; k++) begin
            bus.s_dat_i[k] = slave_data[k];
            bus.s_ack_i[k] = (bus.s_stb_o[k] && !hang[k] && cnt[k] == lat[k]) || stray[k];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NS; k++) begin
            if (!bus.s_stb_o[k]) cnt[k] <= 0;
            else if (!bus.s_ack_i[k]) cnt[k] <= cnt[k] + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the address map expressed as plain address ranges.
    function automatic int ref_slave(input logic [31:0] a);
        if (a < 32'h1000_0000) return 0;
        if (a < 32'h2000_0000) return 1;
        if (a >= 32'h2000_0000 && a < 32'h2000_1000) return 2;
        if (a >= 32'h2000_1000 && a < 32'h2000_2000) return 3;
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return {4'h0, 28'($urandom)};
            1:       return {4'h1, 28'($urandom)};
            2:       return {20'h20000, 12'($urandom)};
            3:       return {20'h20001, 12'($urandom)};
            4:       return {4'($urandom_range(3, 15)), 28'($urandom)};
            default: return 32'h2000_2000 + 32'($urandom_range(0, 32'h0FFF_DFFF));
        endcase
    endfunction

    // Monitor: every ack pops one expectation; read data is checked on the following cycle.
    initial begin : monitor
        bit          pend;
        logic [31:0] pdata;
        exp_t        e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (pend) begin
                    chk("rdata", 64'(bus.m_dat_o), 64'(pdata));
                    pend = 1'b0;
                end
                chk("err_implies_ack", 64'(bus.m_err_o & ~bus.m_ack_o), 64'(0));
                if (bus.m_ack_o === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack: ack with nothing outstanding at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        chk("err_flag", 64'(bus.m_err_o), 64'(e.err));
                        pdata = e.data;
                        pend  = 1'b1;
                    end
                end
            end
        end
    end

    task automatic xfer(input logic [31:0] a, input logic we, input int l,
                        input bit chg, input bit str, input bit hung);
        int            k, cyc_n, exp_cyc;
        logic [NS-1:0] exp_stb;
        logic [31:0]   wd;
        logic [3:0]    sl;
        exp_t          e;
        k = ref_slave(a);
        @(posedge clk); #1;
        for (int j = 0; j < NS; j++) begin
            slave_data[j] = $urandom;
            lat[j]        = l;
        end
        hang = '0;
        if (hung && k >= 0) hang[k] = 1'b1;
        e.err  = (k < 0) || hung;
        e.data = DEF;
        if (!e.err) e.data = slave_data[k];
        sb.push_back(e);
        wd = $urandom;
        sl = 4'($urandom);
        bus.m_adr_i = a;
        bus.m_dat_i = wd;
        bus.m_sel_i = sl;
        bus.m_we_i  = we;
        bus.m_cyc_i = 1'b1;
        bus.m_stb_i = 1'b1;
        stray       = (str && k > 0) ? NS'(1) : '0;
        exp_cyc     = (k < 0) ? 0 : (hung ? TO : l);
        cyc_n       = 0;
        forever begin
            @(negedge clk);
            exp_stb = (k < 0 || (hung && cyc_n == TO)) ? '0 : (NS'(1) << k);
            chk("stb", 64'(bus.s_stb_o), 64'(exp_stb));
            chk("cyc", 64'(bus.s_cyc_o), 64'(exp_stb));
            if (cyc_n == 0) begin
                chk("bcast_adr_dat", {bus.s_adr_o, bus.s_dat_o}, {a, wd});
                chk("bcast_sel_we", 64'({bus.s_sel_o, bus.s_we_o}), 64'({sl, we}));
            end
            if (bus.m_ack_o === 1'b1) begin
                chk("ack_cycle", 64'(cyc_n), 64'(exp_cyc));
                break;
            end
            cyc_n++;
            if (cyc_n > 40) begin
                checks++;
                errors++;
                $display("FAIL ack_timeout: no ack after %0d cycles, adr %h", cyc_n, a);
                break;
            end
            @(posedge clk); #1;
            if (chg && cyc_n == 1) bus.m_adr_i = $urandom;
        end
        @(posedge clk); #1;
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        stray       = '0;
        hang        = '0;
        @(negedge clk);
    endtask

    initial begin : stim
        logic [31:0] a;
        int          l, k;
        reset_n     = 1'b0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.m_we_i  = 1'b0;
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        for (int j = 0; j < NS; j++) begin
            slave_data[j] = $urandom;
            lat[j]        = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 64'(bus.m_ack_o), 64'(0));
        chk("rst_err", 64'(bus.m_err_o), 64'(0));
        chk("rst_stb_cyc", 64'({bus.s_stb_o, bus.s_cyc_o}), 64'(0));
        chk("rst_rdata", 64'(bus.m_dat_o), 64'(slave_data[0]));
        @(posedge clk); #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        xfer(32'h1000_0040, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        xfer(32'h2000_0004, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        xfer(32'h3000_0000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        xfer(32'h2000_0008, 1'b0, 2, 1'b1, 1'b1, 1'b0);
        xfer(32'h2000_1FFC, 1'b0, 1, 1'b0, 1'b0, 1'b0);

        // Reset during a RAM wait state, preceded by an error so read-data state is non-zero.
        xfer(32'h4000_0000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int j = 0; j < NS; j++) begin
            slave_data[j] = $urandom;
            lat[j]        = 6;
        end
        bus.m_adr_i = 32'h1000_0100;
        bus.m_cyc_i = 1'b1;
        bus.m_stb_i = 1'b1;
        @(negedge clk);
        chk("rstw_pre_stb", 64'(bus.s_stb_o), 64'(4'b0010));
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n     = 1'b1;
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        stray       = 4'b0010;
        @(negedge clk);
        chk("rstw_stb", 64'(bus.s_stb_o), 64'(0));
        chk("rstw_ack", 64'(bus.m_ack_o), 64'(0));
        chk("rstw_rdata", 64'(bus.m_dat_o), 64'(slave_data[0]));
        @(posedge clk); #1;
        stray = '0;
        xfer(32'h0000_0200, 1'b0, 1, 1'b0, 1'b0, 1'b0);

`ifdef WB_TIMEOUT_EN
        xfer(32'h2000_1004, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        xfer(32'h1000_0000, 1'b1, 2, 1'b0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 250; i++) begin
            a = rand_addr();
            l = $urandom_range(0, 4);
            k = ref_slave(a);
            xfer(a, 1'($urandom_range(0, 1)), l, 1'($urandom_range(0, 1)),
                 (k > 0 && l > 0) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
